// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder.
// A start in IDLE latches the operands and carry-in. The FSM then spends
// WIDTH/DIGIT cycles in RUN, adding one DIGIT-bit slice per cycle, LSB slice
// first, through a small ripple adder and a single carry flop. Sum, carry-out
// and signed overflow are registered on the edge that leaves RUN. DONE pulses
// for one cycle, then the FSM returns to IDLE.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] a_sl, b_sl, s_sl;
    logic [DIGIT:0]   c;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // Slice adder: ripple DIGIT bits starting from the stored carry.
    // The operand registers shift right, so the active slice is always at bit 0.
    always_comb begin
        a_sl = a_q[DIGIT-1:0];
        b_sl = b_q[DIGIT-1:0];
        s_sl = '0;
        c    = '0;
        c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            s_sl[i]  = a_sl[i] ^ b_sl[i] ^ c[i];
            c[i+1]   = (a_sl[i] & b_sl[i]) | (c[i] & (a_sl[i] ^ b_sl[i]));
        end
    end

    // The partial sum fills from the top, so after N slices it is aligned.
    always_comb begin
        acc_next = (acc_q >> DIGIT) | (WIDTH'(s_sl) << (WIDTH - DIGIT));
        last     = (cnt_q == CW'(N - 1));
    end

    // Next-state and datapath control; everything holds unless told otherwise.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = c[DIGIT];
                acc_d   = acc_next;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    // The final slice holds the MSB: c[DIGIT-1] is the carry
                    // into it and c[DIGIT] the carry out of it.
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = acc_next;
                    cout_d  = c[DIGIT];
                    ovf_d   = c[DIGIT] ^ c[DIGIT-1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Working registers: operands, carry flop, slice counter, partial sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // Result registers: change only when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, operand/result width in bits (legal values 2..64).
REQ-002 SHALL provide parameter DIGIT, default 1, bits added per clock cycle (legal when 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0).
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-006 SHALL provide port a  input  WIDTH  operand A; sampled only on an accepted start.
REQ-007 SHALL provide port b  input  WIDTH  operand B; sampled only on an accepted start.
REQ-008 SHALL provide port cin  input  1  carry-in; sampled only on an accepted start.
REQ-009 SHALL provide port busy  output  1  high while the operation is in RUN.
REQ-010 SHALL provide port done  output  1  one-cycle pulse: results just became valid.
REQ-011 SHALL provide port sum  output  WIDTH  registered result, low WIDTH bits of a+b+cin.
REQ-012 SHALL provide port cout  output  1  registered unsigned carry-out, bit WIDTH of a+b+cin.
REQ-013 SHALL provide port overflow  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-015 SHALL make the IDLE->RUN transition on a clock edge with start=1; at that edge it SHALL latch a, b and cin, and clear the digit counter.
REQ-016 SHALL hold IDLE while start=0.
REQ-017 SHALL, in RUN, add exactly one DIGIT-bit slice per cycle, LSB slice first, through a DIGIT-bit adder plus a single carry flip-flop.
REQ-018 SHALL stay in RUN for exactly N = WIDTH/DIGIT cycles, then go to DONE.
REQ-019 SHALL write sum, cout and overflow on the edge leaving RUN.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE, then return unconditionally to IDLE.
REQ-021 SHALL meet this timing: start accepted at edge 0 -> busy=1 for cycles 1..N -> done=1 in cycle N+1 -> IDLE in cycle N+2.
REQ-022 SHALL ignore start while in RUN or DONE; a new start is first accepted on the edge ending the DONE cycle's successor (IDLE).
REQ-023 SHALL ignore changes on a, b and cin after acceptance.
REQ-024 SHALL hold sum, cout and overflow from one completion until the next completion; an accepted start SHALL NOT disturb them.
REQ-025 SHALL keep busy and done mutually exclusive; both SHALL be 0 in IDLE.
REQ-026 SHALL behave as REQ-021 with N=1 when DIGIT=WIDTH (one RUN cycle).
REQ-027 SHALL wrap sum modulo 2^WIDTH, with the lost bit reported on cout only.

Reset
REQ-028 SHALL, while rst_n=0 and independent of clk, force: state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, digit counter 0, carry flip-flop 0.
REQ-029 SHALL, on reset during RUN or DONE, abort the operation with no done pulse and the outputs set to 0.
REQ-030 SHALL accept start on the first rising edge after rst_n deasserts.

Verification
REQ-031 SHALL pass this scenario (WIDTH=8, DIGIT=1): a=0x7F, b=0x01, cin=0, start at edge 0 -> busy for cycles 1..8, done in cycle 9, sum=0x80, cout=0, overflow=1.
REQ-032 SHALL pass this scenario (WIDTH=8, DIGIT=1): a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1, overflow=0.
REQ-033 SHALL pass this scenario (WIDTH=8, DIGIT=4): a=0x3C, b=0x0F, cin=1 -> done in cycle 3, sum=0x4C, cout=0, overflow=0.
REQ-034 SHALL pass this scenario: start held high and a/b changed throughout an operation -> the result reflects only the operands latched at acceptance; next acceptance occurs in IDLE only.
REQ-035 SHALL pass this scenario: rst_n pulsed low in cycle 4 of a WIDTH=8 run -> busy=0, no done pulse, sum/cout/overflow=0; a fresh start then completes correctly.
REQ-036 SHALL pass this scenario (WIDTH=4, DIGIT in {1,2,4}): all 512 combinations of a, b, cin checked against a+b+cin and the signed-overflow rule; results must match with 0 mismatches.
